// File: rtl/mem_xbar_if.sv
// Bus bundle for mem_xbar: instruction and data master ports plus the
// flattened per-slave request/response buses.
interface mem_xbar_if #(
    parameter int NSLV = 3,
    parameter int AW   = 32
);
    logic               imem_valid;
    logic               imem_instr;
    logic [AW-1:0]      imem_addr;
    logic [31:0]        imem_wdata;
    logic [3:0]         imem_wstrb;
    logic [31:0]        imem_rdata;
    logic               imem_ready;
    logic               imem_err;

    logic               dmem_valid;
    logic               dmem_instr;
    logic [AW-1:0]      dmem_addr;
    logic [31:0]        dmem_wdata;
    logic [3:0]         dmem_wstrb;
    logic [31:0]        dmem_rdata;
    logic               dmem_ready;
    logic               dmem_err;

    logic [NSLV-1:0]    s_valid;
    logic [NSLV-1:0]    s_instr;
    logic [NSLV*AW-1:0] s_addr;
    logic [NSLV*32-1:0] s_wdata;
    logic [NSLV*4-1:0]  s_wstrb;
    logic [NSLV*32-1:0] s_rdata;
    logic [NSLV-1:0]    s_ready;

    modport slave (
        input  imem_valid, imem_instr, imem_addr,
        input  imem_wdata, imem_wstrb,
        output imem_rdata, imem_ready, imem_err,
        input  dmem_valid, dmem_instr, dmem_addr,
        input  dmem_wdata, dmem_wstrb,
        output dmem_rdata, dmem_ready, dmem_err,
        output s_valid, s_instr, s_addr,
        output s_wdata, s_wstrb,
        input  s_rdata, s_ready
    );

    modport master (
        output imem_valid, imem_instr, imem_addr,
        output imem_wdata, imem_wstrb,
        input  imem_rdata, imem_ready, imem_err,
        output dmem_valid, dmem_instr, dmem_addr,
        output dmem_wdata, dmem_wstrb,
        input  dmem_rdata, dmem_ready, dmem_err,
        input  s_valid, s_instr, s_addr,
        input  s_wdata, s_wstrb,
        output s_rdata, s_ready
    );
endinterface

// File: rtl/mem_xbar.sv
// Two-master (imem=0, dmem=1) to NSLV-slave memory crossbar with
// per-master pending buffer, per-slave ownership and decode-error reply.
module mem_xbar #(
    parameter int NSLV = 3,
    parameter int AW   = 32,
    parameter logic [NSLV*AW-1:0] SLV_BASE =
        {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NSLV*AW-1:0] SLV_TOP =
        {32'h2000_1000, 32'h1001_0000, 32'h0001_0000},
    parameter int ARB_MODE = 0
) (
    input logic clk,
    input logic rst,
    mem_xbar_if.slave bus
);
    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {
        S_IDLE, S_PEND, S_WAIT, S_ERR
    } state_t;

    state_t          r_st [2];
    state_t          w_nxt [2];
    logic [AW-1:0]   r_addr [2];
    logic [31:0]     r_wdata [2];
    logic [3:0]      r_wstrb [2];
    logic [1:0]      r_instr;
    logic [NSLV-1:0] r_busy;
    logic [NSLV-1:0] r_owner;
    logic            r_rr;

    logic [1:0]      w_vld, w_ins;
    logic [AW-1:0]   w_iaddr [2];
    logic [31:0]     w_iwdata [2];
    logic [3:0]      w_iwstrb [2];

    logic [1:0]      w_req, w_pend, w_hit;
    logic [1:0]      w_cand, w_gnt, w_rsp, w_err;
    logic            w_arb;
    logic [AW-1:0]   w_addr [2];
    logic [31:0]     w_wdata [2];
    logic [3:0]      w_wstrb [2];
    logic [1:0]      w_instr;
    logic [SW-1:0]   w_tgt [2];
    logic [31:0]     w_rdata [2];
    logic [NSLV-1:0] w_clr;

    logic [NSLV-1:0]    w_sv, w_si;
    logic [NSLV*AW-1:0] w_sa;
    logic [NSLV*32-1:0] w_sd;
    logic [NSLV*4-1:0]  w_ss;

    function automatic logic [SW:0] f_decode(
        input logic [AW-1:0] a
    );
        logic          hit;
        logic [SW-1:0] idx;
        hit = 1'b0;
        idx = '0;
        // Descending scan so the lowest matching index wins
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (a >= SLV_BASE[i*AW +: AW] &&
                a <  SLV_TOP[i*AW +: AW]) begin
                hit = 1'b1;
                idx = SW'(i);
            end
        end
        return {hit, idx};
    endfunction

    assign w_vld       = {bus.dmem_valid, bus.imem_valid};
    assign w_ins       = {bus.dmem_instr, bus.imem_instr};
    assign w_iaddr[0]  = bus.imem_addr;
    assign w_iaddr[1]  = bus.dmem_addr;
    assign w_iwdata[0] = bus.imem_wdata;
    assign w_iwdata[1] = bus.dmem_wdata;
    assign w_iwstrb[0] = bus.imem_wstrb;
    assign w_iwstrb[1] = bus.dmem_wstrb;

    always_comb begin
        for (int m = 0; m < 2; m++) begin
            w_pend[m]  = (r_st[m] == S_PEND);
            w_req[m]   = rst && (w_pend[m] ||
                         (r_st[m] == S_IDLE && w_vld[m]));
            w_addr[m]  = w_pend[m] ? r_addr[m]  : w_iaddr[m];
            w_wdata[m] = w_pend[m] ? r_wdata[m] : w_iwdata[m];
            w_wstrb[m] = w_pend[m] ? r_wstrb[m] : w_iwstrb[m];
            w_instr[m] = w_pend[m] ? r_instr[m] : w_ins[m];
            {w_hit[m], w_tgt[m]} = f_decode(w_addr[m]);
            w_cand[m]  = w_req[m] && w_hit[m] &&
                         !r_busy[w_tgt[m]];
        end
    end

    always_comb begin
        w_gnt = w_cand;
        w_arb = 1'b0;
        if (&w_cand && w_tgt[0] == w_tgt[1]) begin
            if (w_pend[0] && !w_pend[1]) begin
                w_gnt = 2'b01;
            end else if (w_pend[1] && !w_pend[0]) begin
                w_gnt = 2'b10;
            end else begin
                w_arb = 1'b1;
                w_gnt = (ARB_MODE != 0 && r_rr) ?
                        2'b01 : 2'b10;
            end
        end
    end

    always_comb begin
        w_sv = '0;
        w_si = '0;
        w_sa = '0;
        w_sd = '0;
        w_ss = '0;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < NSLV; i++) begin
                if (w_gnt[m] && w_tgt[m] == SW'(i)) begin
                    w_sv[i] = 1'b1;
                    w_si[i] = w_instr[m];
                    w_sa[i*AW +: AW] =
                        w_addr[m] - SLV_BASE[i*AW +: AW];
                    w_sd[i*32 +: 32] = w_wdata[m];
                    w_ss[i*4 +: 4]   = w_wstrb[m];
                end
            end
        end
    end

    assign bus.s_valid = w_sv;
    assign bus.s_instr = w_si;
    assign bus.s_addr  = w_sa;
    assign bus.s_wdata = w_sd;
    assign bus.s_wstrb = w_ss;

    always_comb begin
        w_rsp      = '0;
        w_rdata[0] = '0;
        w_rdata[1] = '0;
        // Responses from slaves nobody owns are dropped here
        w_clr = r_busy & bus.s_ready & {NSLV{rst}};
        for (int i = 0; i < NSLV; i++) begin
            if (w_clr[i]) begin
                w_rsp[r_owner[i]]   = 1'b1;
                w_rdata[r_owner[i]] = bus.s_rdata[i*32 +: 32];
            end
        end
        for (int m = 0; m < 2; m++) begin
            w_err[m] = rst && (r_st[m] == S_ERR);
        end
    end

    assign bus.imem_ready = w_rsp[0] | w_err[0];
    assign bus.imem_rdata = w_rdata[0];
    assign bus.imem_err   = w_err[0];
    assign bus.dmem_ready = w_rsp[1] | w_err[1];
    assign bus.dmem_rdata = w_rdata[1];
    assign bus.dmem_err   = w_err[1];

    always_comb begin
        for (int m = 0; m < 2; m++) begin
            w_nxt[m] = r_st[m];
            unique case (r_st[m])
                S_IDLE: begin
                    if (w_vld[m]) begin
                        if (w_gnt[m])      w_nxt[m] = S_WAIT;
                        else if (w_hit[m]) w_nxt[m] = S_PEND;
                        else               w_nxt[m] = S_ERR;
                    end
                end
                S_PEND: if (w_gnt[m]) w_nxt[m] = S_WAIT;
                S_WAIT: if (w_rsp[m]) w_nxt[m] = S_IDLE;
                S_ERR:  w_nxt[m] = S_IDLE;
                default: w_nxt[m] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_st[0] <= S_IDLE;
            r_st[1] <= S_IDLE;
        end else begin
            r_st[0] <= w_nxt[0];
            r_st[1] <= w_nxt[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy  <= '0;
            r_owner <= '0;
            r_rr    <= 1'b0;
            r_instr <= '0;
            for (int m = 0; m < 2; m++) begin
                r_addr[m]  <= '0;
                r_wdata[m] <= '0;
                r_wstrb[m] <= '0;
            end
        end else begin
            for (int i = 0; i < NSLV; i++) begin
                if (w_clr[i]) r_busy[i] <= 1'b0;
            end
            for (int m = 0; m < 2; m++) begin
                if (w_gnt[m]) begin
                    r_busy[w_tgt[m]]  <= 1'b1;
                    r_owner[w_tgt[m]] <= 1'(m);
                end
                if (r_st[m] == S_IDLE && w_vld[m] &&
                    w_hit[m] && !w_gnt[m]) begin
                    r_addr[m]  <= w_iaddr[m];
                    r_wdata[m] <= w_iwdata[m];
                    r_wstrb[m] <= w_iwstrb[m];
                    r_instr[m] <= w_ins[m];
                end
            end
            if (ARB_MODE != 0 && w_arb) r_rr <= !r_rr;
        end
    end
endmodule

// File: tb/tb_mem_xbar.sv
// Directed bench for mem_xbar: dut0 uses fixed-priority arbitration,
// dut1 round-robin; both share a latency-programmable slave model.
module tb_mem_xbar;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mem_xbar_if #(.NSLV(3), .AW(32)) b0 ();
    mem_xbar_if #(.NSLV(3), .AW(32)) b1 ();

    mem_xbar #(.ARB_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0)
    );
    mem_xbar #(.ARB_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  w_sv  [2];
    logic [95:0] w_sa  [2];
    logic [2:0]  r_srdy [2];
    logic [95:0] r_srd  [2];
    int          lat  [2][3];
    int          cnt  [2][3];
    logic [31:0] hold [2][3];

    assign w_sv[0]    = b0.s_valid;
    assign w_sv[1]    = b1.s_valid;
    assign w_sa[0]    = b0.s_addr;
    assign w_sa[1]    = b1.s_addr;
    assign b0.s_ready = r_srdy[0];
    assign b1.s_ready = r_srdy[1];
    assign b0.s_rdata = r_srd[0];
    assign b1.s_rdata = r_srd[1];

    // Slave reply data: A0ss_oooo with ss = slave index, oooo = offset
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 3; i++) begin
                r_srdy[d][i] <= 1'b0;
                r_srd[d][i*32 +: 32] <= '0;
                if (cnt[d][i] == 1) begin
                    r_srdy[d][i] <= 1'b1;
                    r_srd[d][i*32 +: 32] <= hold[d][i];
                end
                if (cnt[d][i] > 0) cnt[d][i] <= cnt[d][i] - 1;
                if (w_sv[d][i]) begin
                    if (lat[d][i] <= 1) begin
                        r_srdy[d][i] <= 1'b1;
                        r_srd[d][i*32 +: 32] <= 32'hA000_0000 |
                            (32'(i) << 16) |
                            {16'h0, w_sa[d][i*32 +: 16]};
                    end else begin
                        cnt[d][i]  <= lat[d][i] - 1;
                        hold[d][i] <= 32'hA000_0000 |
                            (32'(i) << 16) |
                            {16'h0, w_sa[d][i*32 +: 16]};
                    end
                end
            end
        end
    end

    task automatic chk(input string tag,
                       input logic [95:0] obs,
                       input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 3; i++) begin
                lat[d][i] = 1;
                cnt[d][i] = 0;
                hold[d][i] = '0;
            end
            r_srdy[d] = '0;
            r_srd[d]  = '0;
        end
        b0.imem_valid = 0; b0.imem_instr = 0; b0.imem_addr = 0;
        b0.imem_wdata = 0; b0.imem_wstrb = 0;
        b0.dmem_valid = 0; b0.dmem_instr = 0; b0.dmem_addr = 0;
        b0.dmem_wdata = 0; b0.dmem_wstrb = 0;
        b1.imem_valid = 0; b1.imem_instr = 0; b1.imem_addr = 0;
        b1.imem_wdata = 0; b1.imem_wstrb = 0;
        b1.dmem_valid = 0; b1.dmem_instr = 0; b1.dmem_addr = 0;
        b1.dmem_wdata = 0; b1.dmem_wstrb = 0;

        // Reset: requests are masked
        nxt();
        b0.imem_valid = 1; b0.imem_instr = 1;
        b0.imem_addr = 32'h10;
        #1;
        chk("rst_svalid", 96'(b0.s_valid), 96'h0);
        chk("rst_iready", 96'(b0.imem_ready), 96'h0);
        chk("rst_dready", 96'(b0.dmem_ready), 96'h0);
        nxt();
        rst = 1'b1;
        #1;
        chk("t1_svalid", 96'(b0.s_valid), 96'h1);
        chk("t1_saddr", 96'(b0.s_addr[31:0]), 96'h10);
        chk("t1_sinstr", 96'(b0.s_instr), 96'h1);
        chk("t1_iready0", 96'(b0.imem_ready), 96'h0);
        nxt();
        b0.imem_valid = 0; b0.imem_instr = 0;
        #1;
        chk("t1_iready", 96'(b0.imem_ready), 96'h1);
        chk("t1_rdata", 96'(b0.imem_rdata), 96'hA000_0010);
        chk("t1_err", 96'(b0.imem_err), 96'h0);
        nxt();
        #1;
        chk("t1_idle_rdy", 96'(b0.imem_ready), 96'h0);
        chk("t1_idle_rd", 96'(b0.imem_rdata), 96'h0);

        // Conflict on slave1, fixed priority
        lat[0][1] = 3;
        nxt();
        b0.imem_valid = 1; b0.imem_addr = 32'h1000_0008;
        b0.dmem_valid = 1; b0.dmem_addr = 32'h1000_0024;
        b0.dmem_wdata = 32'hDEAD_BEEF; b0.dmem_wstrb = 4'hF;
        #1;
        chk("t2_svalid", 96'(b0.s_valid), 96'h2);
        chk("t2_saddr", 96'(b0.s_addr[63:32]), 96'h24);
        chk("t2_wdata", 96'(b0.s_wdata[63:32]), 96'hDEAD_BEEF);
        chk("t2_wstrb", 96'(b0.s_wstrb[7:4]), 96'hF);
        nxt();
        b0.imem_valid = 0; b0.imem_addr = 0;
        b0.dmem_valid = 0; b0.dmem_addr = 0;
        b0.dmem_wdata = 0; b0.dmem_wstrb = 0;
        #1;
        chk("t2_busy1", 96'(b0.s_valid), 96'h0);
        nxt();
        #1;
        chk("t2_busy2", 96'(b0.s_valid), 96'h0);
        chk("t2_dnot", 96'(b0.dmem_ready), 96'h0);
        nxt();
        #1;
        chk("t2_dready", 96'(b0.dmem_ready), 96'h1);
        chk("t2_drdata", 96'(b0.dmem_rdata), 96'hA001_0024);
        chk("t2_inot", 96'(b0.imem_ready), 96'h0);
        chk("t2_busy3", 96'(b0.s_valid), 96'h0);
        nxt();
        #1;
        chk("t2_pend_sv", 96'(b0.s_valid), 96'h2);
        chk("t2_pend_sa", 96'(b0.s_addr[63:32]), 96'h8);
        repeat (3) nxt();
        #1;
        chk("t2_iready", 96'(b0.imem_ready), 96'h1);
        chk("t2_irdata", 96'(b0.imem_rdata), 96'hA001_0008);
        lat[0][1] = 1;

        // Round-robin: four conflicts on slave0
        for (int k = 0; k < 4; k++) begin
            nxt();
            b1.imem_valid = 1; b1.imem_addr = 32'h100;
            b1.dmem_valid = 1; b1.dmem_addr = 32'h200;
            #1;
            chk("t3_win", 96'(b1.s_addr[31:0]),
                (k % 2 == 0) ? 96'h200 : 96'h100);
            nxt();
            b1.imem_valid = 0; b1.dmem_valid = 0;
            nxt();
            #1;
            chk("t3_lose", 96'(b1.s_addr[31:0]),
                (k % 2 == 0) ? 96'h100 : 96'h200);
            nxt();
        end

        // Unmapped dmem access
        nxt();
        b0.dmem_valid = 1; b0.dmem_addr = 32'hFFFF_0000;
        #1;
        chk("t4_svalid", 96'(b0.s_valid), 96'h0);
        chk("t4_rdy0", 96'(b0.dmem_ready), 96'h0);
        nxt();
        b0.dmem_valid = 0; b0.dmem_addr = 0;
        #1;
        chk("t4_ready", 96'(b0.dmem_ready), 96'h1);
        chk("t4_err", 96'(b0.dmem_err), 96'h1);
        chk("t4_rdata", 96'(b0.dmem_rdata), 96'h0);
        nxt();
        #1;
        chk("t4_rdy_off", 96'(b0.dmem_ready), 96'h0);
        chk("t4_err_off", 96'(b0.dmem_err), 96'h0);

        // Concurrent outstanding, out-of-order responses
        lat[0][0] = 5;
        nxt();
        b0.imem_valid = 1; b0.imem_addr = 32'h40;
        b0.dmem_valid = 1; b0.dmem_addr = 32'h2000_0004;
        #1;
        chk("t5_svalid", 96'(b0.s_valid), 96'h5);
        nxt();
        b0.imem_valid = 0; b0.imem_addr = 0;
        b0.dmem_valid = 0; b0.dmem_addr = 0;
        #1;
        chk("t5_dready", 96'(b0.dmem_ready), 96'h1);
        chk("t5_drdata", 96'(b0.dmem_rdata), 96'hA002_0004);
        chk("t5_inot", 96'(b0.imem_ready), 96'h0);
        for (int k = 0; k < 3; k++) begin
            nxt();
            #1;
            chk("t5_quiet", 96'({b0.imem_ready, b0.dmem_ready}),
                96'h0);
        end
        nxt();
        #1;
        chk("t5_iready", 96'(b0.imem_ready), 96'h1);
        chk("t5_irdata", 96'(b0.imem_rdata), 96'hA000_0040);
        chk("t5_dnot", 96'(b0.dmem_ready), 96'h0);
        lat[0][0] = 1;

        // Reset while slave1 busy
        lat[0][1] = 6;
        nxt();
        b0.dmem_valid = 1; b0.dmem_addr = 32'h1000_0000;
        #1;
        chk("t6_issue", 96'(b0.s_valid), 96'h2);
        nxt();
        b0.dmem_valid = 0; b0.dmem_addr = 0;
        nxt();
        rst = 1'b0;
        b0.imem_valid = 1; b0.imem_addr = 32'h10;
        #1;
        chk("t6_rst_sv", 96'(b0.s_valid), 96'h0);
        chk("t6_rst_sa", b0.s_addr, 96'h0);
        chk("t6_rst_rdy", 96'({b0.imem_ready, b0.dmem_ready}),
            96'h0);
        nxt();
        rst = 1'b1;
        b0.imem_valid = 0; b0.imem_addr = 0;
        lat[0][1] = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t6_late", 96'(b0.dmem_ready), 96'h0);
            nxt();
        end
        b0.dmem_valid = 1; b0.dmem_addr = 32'h1000_0030;
        #1;
        chk("t6_new_sv", 96'(b0.s_valid), 96'h2);
        chk("t6_new_sa", 96'(b0.s_addr[63:32]), 96'h30);
        nxt();
        b0.dmem_valid = 0; b0.dmem_addr = 0;
        #1;
        chk("t6_new_rdy", 96'(b0.dmem_ready), 96'h1);
        chk("t6_new_rd", 96'(b0.dmem_rdata), 96'hA001_0030);

        repeat (2) nxt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
